// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and constants for the MAC sequencer.
// State encoding, MAC result geometry and default parameter values.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a0*b0 + a1*b1 for signed 8-bit operands; the MAC result is
  // consumed as this sum sign-extended by one bit.
  localparam int MAC_PRODUCT_SUM_W = 17;
  localparam int MAC_RESULT_W      = 32;

  localparam int DEF_MAC_LATENCY = 3;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_LEN_WIDTH   = 16;

endpackage

// File: rtl/mac_valid_pipe.sv
// mac_valid_pipe: shadow valid shift register tracking beats in flight
// through the operand register and the hard MAC.
module mac_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic push,
  output logic tail,
  output logic all_zero_next
);

  logic [DEPTH-1:0] pipe_reg;
  logic [DEPTH-1:0] pipe_next;

  // Stage 0 takes the new valid bit, every later stage takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = push;
      end else begin : g_body
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  // Shift every cycle; asynchronous clear discards anything in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  assign tail = pipe_reg[DEPTH-1];
  // The pipe becomes all-zero at the next shift when nothing is pushed and
  // only the tail (which retires on this edge) may still be set.
  assign all_zero_next = ~|pipe_reg[DEPTH-2:0];

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences the dual-lane 8-bit hard MAC for one dot-product
// command at a time and returns the accumulated result on a valid/ready port.
// Optional build macro: MAC_SEQ_SAT_EN (saturating accumulation + sat_flag).
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int MAC_LATENCY = DEF_MAC_LATENCY,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    ivalid,
  output logic                    iready,
  input  logic [7:0]              dataa_0,
  input  logic [7:0]              datab_0,
  input  logic [7:0]              dataa_1,
  input  logic [7:0]              datab_1,
  output logic [7:0]              mac_dataa_0,
  output logic [7:0]              mac_datab_0,
  output logic [7:0]              mac_dataa_1,
  output logic [7:0]              mac_datab_1,
  input  logic [MAC_RESULT_W-1:0] mac_result,
  output logic                    ovalid,
  input  logic                    oready,
  output logic [ACC_WIDTH-1:0]    result,
`ifdef MAC_SEQ_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  localparam int PIPE_DEPTH = MAC_LATENCY + 1;
  localparam int SUM_W      = MAC_PRODUCT_SUM_W + 1;

  state_t                       state_reg;
  state_t                       state_next;
  logic                         cmd_ready_reg;
  logic [LEN_WIDTH-1:0]         remaining_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic [7:0]                   mac_a0_reg;
  logic [7:0]                   mac_b0_reg;
  logic [7:0]                   mac_a1_reg;
  logic [7:0]                   mac_b1_reg;
  logic                         cmd_accept;
  logic                         beat_accept;
  logic                         pipe_tail;
  logic                         pipe_all_zero_next;
  logic signed [SUM_W-1:0]      beat_sum;
  logic signed [ACC_WIDTH-1:0]  beat_ext;
  logic                         unused_mac_hi;

  // Only the low bits carry the product sum; the rest is sign fill.
  assign beat_sum      = mac_result[SUM_W-1:0];
  assign beat_ext      = ACC_WIDTH'(beat_sum);
  assign unused_mac_hi = ^mac_result[MAC_RESULT_W-1:SUM_W];

  mac_valid_pipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_valid_pipe (
    .clock         (clock),
    .resetn        (resetn),
    .push          (beat_accept),
    .tail          (pipe_tail),
    .all_zero_next (pipe_all_zero_next)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    cmd_accept  = 1'b0;
    beat_accept = 1'b0;
    iready      = 1'b0;
    ovalid      = 1'b0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          cmd_accept = 1'b1;
          state_next = (cmd_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        iready = 1'b1;
        if (ivalid) begin
          beat_accept = 1'b1;
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave once the last beat retires from the tail on this edge, so
        // its accumulation and the DONE entry land together.
        if (pipe_all_zero_next) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ovalid = 1'b1;
        if (oready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // cmd_ready is registered so that it reads 0 while reset is asserted and
  // rises the cycle after the sequencer arrives in IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cmd_ready_reg <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == IDLE);
    end
  end

  assign cmd_ready = cmd_ready_reg;

  // Operand register feeding the MAC; holds its value between beats.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mac_a0_reg <= '0;
      mac_b0_reg <= '0;
      mac_a1_reg <= '0;
      mac_b1_reg <= '0;
    end else if (beat_accept) begin
      mac_a0_reg <= dataa_0;
      mac_b0_reg <= datab_0;
      mac_a1_reg <= dataa_1;
      mac_b1_reg <= datab_1;
    end
  end

  assign mac_dataa_0 = mac_a0_reg;
  assign mac_datab_0 = mac_b0_reg;
  assign mac_dataa_1 = mac_a1_reg;
  assign mac_datab_1 = mac_b1_reg;

`ifdef MAC_SEQ_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_wide;
  logic               sat_hit;
  logic               sat_reg;

  // Add with one guard bit; clamp when the guard and sign bits disagree.
  always_comb begin
    sum_wide = {acc_reg[ACC_WIDTH-1], acc_reg} + {beat_ext[ACC_WIDTH-1], beat_ext};
    sat_hit  = 1'b0;
    acc_next = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      sat_hit  = 1'b1;
      acc_next = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  // Sticky saturation indicator for the current command.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sat_reg <= 1'b0;
    end else if (cmd_accept) begin
      sat_reg <= 1'b0;
    end else if (pipe_tail && sat_hit) begin
      sat_reg <= 1'b1;
    end
  end

  assign sat_flag = sat_reg & ovalid;
`else
  // Plain two's-complement accumulation wrapping at ACC_WIDTH.
  always_comb begin
    acc_next = acc_reg + beat_ext;
  end
`endif

  // Beat counter and accumulator; only beats leaving the pipe tail count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      remaining_reg <= '0;
      acc_reg       <= '0;
    end else if (cmd_accept) begin
      remaining_reg <= cmd_len;
      acc_reg       <= '0;
    end else begin
      if (beat_accept) begin
        remaining_reg <= remaining_reg - LEN_WIDTH'(1);
      end
      if (pipe_tail) begin
        acc_reg <= acc_next;
      end
    end
  end

  assign result = acc_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl with an ideal hard-MAC
// model and a scoreboard of expected dot products.
module tb_mac_seq_ctrl;

  localparam int L  = 3;
  localparam int AW = 18;
  localparam int LW = 16;
  localparam logic [31:0] MASK = (32'd1 << AW) - 32'd1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          ivalid = 1'b0;
  logic          iready;
  logic [7:0]    dataa_0 = '0, datab_0 = '0, dataa_1 = '0, datab_1 = '0;
  logic [7:0]    mac_dataa_0, mac_datab_0, mac_dataa_1, mac_datab_1;
  logic [31:0]   mac_result;
  logic          ovalid;
  logic          oready = 1'b0;
  logic [AW-1:0] result;
  logic          busy;
`ifdef MAC_SEQ_SAT_EN
  logic          sat_flag;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int beat_cnt = 0;
  int m_acc;
  bit m_sat;
  int last_acc;
  int cmd_cyc;
  int exp_q[$];
  bit sat_q[$];

  always #5 clock = ~clock;

  mac_seq_ctrl #(
    .MAC_LATENCY(L),
    .ACC_WIDTH  (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .ivalid      (ivalid),
    .iready      (iready),
    .dataa_0     (dataa_0),
    .datab_0     (datab_0),
    .dataa_1     (dataa_1),
    .datab_1     (datab_1),
    .mac_dataa_0 (mac_dataa_0),
    .mac_datab_0 (mac_datab_0),
    .mac_dataa_1 (mac_dataa_1),
    .mac_datab_1 (mac_datab_1),
    .mac_result  (mac_result),
    .ovalid      (ovalid),
    .oready      (oready),
    .result      (result),
`ifdef MAC_SEQ_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .busy        (busy)
  );

  function automatic int ideal(input logic [7:0] a0, b0, a1, b1);
    int x0, y0, x1, y1;
    x0 = int'($signed(a0));
    y0 = int'($signed(b0));
    x1 = int'($signed(a1));
    y1 = int'($signed(b1));
    return x0 * y0 + x1 * y1;
  endfunction

  // Ideal hard MAC: result of the operands seen L cycles earlier.
  logic [31:0] mac_pipe [L];
  always @(posedge clock) begin
    mac_pipe[0] <= ideal(mac_dataa_0, mac_datab_0, mac_dataa_1, mac_datab_1);
    for (int i = 1; i < L; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_result = mac_pipe[L-1];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ivalid && iready) beat_cnt <= beat_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference accumulation: wrap or clamp to the signed AW-bit range.
  task automatic m_add(input int p);
    longint s, lim;
    lim = longint'(1) << (AW - 1);
    s = longint'(m_acc) + longint'(p);
`ifdef MAC_SEQ_SAT_EN
    if (s > lim - 1) begin s = lim - 1; m_sat = 1'b1; end
    else if (s < -lim) begin s = -lim; m_sat = 1'b1; end
`else
    s = s & ((lim << 1) - 1);
    if (s >= lim) s = s - (lim << 1);
`endif
    m_acc = int'(s);
  endtask

  task automatic push_expect();
    exp_q.push_back(m_acc);
    sat_q.push_back(m_sat);
  endtask

  task automatic do_cmd(input int len);
    int n = 0;
    m_acc = 0;
    m_sat = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_len = LW'(len);
    while (!cmd_ready && n < 20) begin @(negedge clock); n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_cyc = cyc;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    if (len == 0) push_expect();
  endtask

  task automatic send_beat(input int a0, b0, a1, b1);
    int n = 0;
    @(negedge clock);
    ivalid = 1'b1;
    dataa_0 = 8'(a0); datab_0 = 8'(b0); dataa_1 = 8'(a1); datab_1 = 8'(b1);
    while (!iready && n < 20) begin @(negedge clock); n++; end
    check("iready_wait", 32'(iready), 32'd1);
    last_acc = cyc;
    m_add(ideal(8'(a0), 8'(b0), 8'(a1), 8'(b1)));
    @(posedge clock); #1;
    ivalid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    int n = 0;
    @(negedge clock);
    while (!ovalid && n < 50) begin @(negedge clock); n++; end
    check("ovalid_wait", 32'(ovalid), 32'd1);
    c = cyc;
  endtask

  task automatic get_result(input string tag);
    int e;
    bit s;
    e = exp_q.pop_front();
    s = sat_q.pop_front();
    check(tag, 32'(result), 32'(e) & MASK);
`ifdef MAC_SEQ_SAT_EN
    check({tag, "_sat"}, 32'(sat_flag), 32'(s));
`endif
  endtask

  // Called at a negedge with ovalid high: take the result on the next edge.
  task automatic accept_out();
    oready = 1'b1;
    @(posedge clock); #1;
    oready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;

    // Reset values while resetn is held low.
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_iready", 32'(iready), 32'd0);
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_mac_a0", 32'(mac_dataa_0), 32'd0);
    resetn = 1'b1;

    // Directed three-beat dot product.
    do_cmd(3);
    send_beat(1, 2, 3, 4);
    send_beat(-5, 6, 7, -8);
    send_beat(127, 127, -128, -128);
    push_expect();
    wait_out(c);
    check("t1_latency", 32'(c - last_acc), 32'(L + 2));
    check("t1_const", 32'(result), 32'd32441);
    get_result("t1_result");
    accept_out();
    check("t1_ovalid_low", 32'(ovalid), 32'd0);
    check("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    $display("t1 len=3 result=%0d", $signed(result));

    // Zero-length command with oready already high: one-cycle ovalid.
    oready = 1'b1;
    do_cmd(0);
    @(negedge clock);
    check("t2_ovalid", 32'(ovalid), 32'd1);
    check("t2_latency", 32'(cyc - cmd_cyc), 32'd1);
    check("t2_iready", 32'(iready), 32'd0);
    get_result("t2_result");
    @(negedge clock);
    check("t2_ovalid_pulse", 32'(ovalid), 32'd0);
    oready = 1'b0;
    $display("t2 len=0 done");

    // Alternating ivalid, then ivalid stuck high while draining.
    base = beat_cnt;
    do_cmd(4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      ivalid = ((k % 2) == 0);
      case (k / 2)
        0: begin dataa_0 = 8'd1; datab_0 = 8'd1; dataa_1 = 8'd1; datab_1 = 8'd1; end
        1: begin dataa_0 = -8'sd2; datab_0 = 8'd3; dataa_1 = 8'd4; datab_1 = 8'd5; end
        2: begin dataa_0 = 8'd10; datab_0 = -8'sd10; dataa_1 = 8'd6; datab_1 = 8'd6; end
        default: begin dataa_0 = -8'sd128; datab_0 = 8'd127; dataa_1 = 8'd0; datab_1 = 8'd0; end
      endcase
      if (ivalid) begin
        last_acc = cyc;
        m_add(ideal(dataa_0, datab_0, dataa_1, datab_1));
      end
    end
    @(negedge clock);
    ivalid = 1'b1;
    dataa_0 = 8'd100; datab_0 = 8'd100; dataa_1 = 8'd100; datab_1 = 8'd100;
    push_expect();
    wait_out(c);
    check("t3_latency", 32'(c - last_acc), 32'(L + 2));
    check("t3_beats", 32'(beat_cnt - base), 32'd4);
    get_result("t3_result");
    ivalid = 1'b0;
    accept_out();
    $display("t3 gaps result=%0d beats=%0d", $signed(result), beat_cnt - base);

    // Output backpressure with command and operand requests pending.
    do_cmd(2);
    send_beat(20, 30, -7, 9);
    send_beat(-100, 50, 3, 3);
    push_expect();
    wait_out(c);
    cmd_valid = 1'b1;
    ivalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("t4_hold_result", 32'(result), 32'(exp_q[0]) & MASK);
      check("t4_cmd_ready", 32'(cmd_ready), 32'd0);
      check("t4_iready", 32'(iready), 32'd0);
      check("t4_ovalid", 32'(ovalid), 32'd1);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    ivalid = 1'b0;
    get_result("t4_result");
    accept_out();
    check("t4_release_busy", 32'(busy), 32'd0);
    check("t4_release_ready", 32'(cmd_ready), 32'd1);
    $display("t4 backpressure result=%0d", $signed(result));

    // Reset in the middle of a command.
    do_cmd(5);
    send_beat(9, 9, 9, 9);
    send_beat(-9, 9, 9, 9);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("t5_rst_ovalid", 32'(ovalid), 32'd0);
    check("t5_rst_iready", 32'(iready), 32'd0);
    check("t5_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    check("t5_rst_mac_a0", 32'(mac_dataa_0), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    do_cmd(1);
    send_beat(2, 3, 0, 0);
    push_expect();
    wait_out(c);
    check("t5_const", 32'(result), 32'd6);
    get_result("t5_result");
    accept_out();
    $display("t5 post-reset result=%0d", $signed(result));

    // Overflow of the 18-bit accumulator.
    do_cmd(10);
    for (int k = 0; k < 10; k++) send_beat(127, 127, 127, 127);
    push_expect();
    wait_out(c);
`ifdef MAC_SEQ_SAT_EN
    check("t6_const", 32'(result), 32'd131071);
`else
    check("t6_const", 32'(result), 32'd60436);
`endif
    get_result("t6_result");
    accept_out();
    $display("t6 overflow result=%0d", $signed(result));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequences the dual-lane 8-bit hard MAC. That MAC is fixed-latency, always-enabled, always-ready and has no valid/ready of its own.
- Accepts one dot-product command (vector length in beats) and a valid/ready operand stream of two 8-bit pairs per beat.
- Drives the MAC, tracks in-flight beats with a shadow valid pipeline and accumulates the per-beat MAC results.
- Presents one accumulated result per command on a valid/ready output.
- Sits between the PE operand buffers and the PE output path.

Parameters:
MAC_LATENCY, 3, clock cycles from MAC operand inputs to the matching result word (must be >= 1)
ACC_WIDTH, 32, accumulator and output result width (must be >= 18)
LEN_WIDTH, 16, width of the command length field

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_len  in  LEN_WIDTH  number of operand beats in this dot product (0 legal)
ivalid  in  1  operand beat valid
iready  out  1  operand beat accepted when ivalid & iready
dataa_0, datab_0, dataa_1, datab_1  in  8 each  signed operand pairs
mac_dataa_0, mac_datab_0, mac_dataa_1, mac_datab_1  out  8 each  registered operands to MAC
mac_result  in  32  MAC result, signed, = a0*b0 + a1*b1 of the beat issued MAC_LATENCY cycles earlier
ovalid  out  1  result valid
oready  in  1  result accepted when ovalid & oready
result  out  ACC_WIDTH  accumulated signed dot product
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator 0, beat counter 0, shadow valid pipe cleared.
- Assertion of resetn low mid-command aborts the command immediately; results in flight are discarded.
- States:
  - IDLE: cmd_ready=1. On accept, latch cmd_len, clear accumulator, load remaining=cmd_len. Go to RUN if cmd_len!=0, else DONE with result=0.
  - RUN: iready=1. Each accepted beat registers its operands onto mac_* (one cycle), pushes 1 into the shadow pipe and decrements remaining. The beat that takes remaining to 0 moves the state to DRAIN. Cycles with no accepted beat push 0.
  - DRAIN: iready=0. Wait until the shadow pipe is all-zero, then go to DONE.
  - DONE: ovalid=1 and result holds the accumulator stable until oready. The accept cycle moves to IDLE; cmd_ready is first seen high the following cycle.
- Shadow pipe:
  - Depth = MAC_LATENCY + 1; the extra stage covers the operand register.
  - When the tail bit is 1, accumulator += sign-extended mac_result[17:0], the meaningful 17-bit sum sign-extended to 18 bits.
  - Accumulation wraps modulo 2^ACC_WIDTH.
- mac_* hold the last value when idle; the MAC's output is ignored unless the pipe tail is 1.
- Latency: last beat accepted at cycle t, ovalid rises at cycle t+MAC_LATENCY+2.
- Throughput: one beat per cycle in RUN. No new command overlaps a pending result.
- ivalid in IDLE/DRAIN/DONE is not accepted. cmd_valid outside IDLE is not accepted.
- oready held high in DONE: one-cycle ovalid pulse.

Optional Feature:
MAC_SEQ_SAT_EN
- Defined: accumulation saturates to the signed ACC_WIDTH range. One extra output port, sat_flag (1 bit), is high together with ovalid if any saturation occurred during the command. sat_flag resets to 0 and is cleared at command accept.
- Undefined: the accumulator wraps and the sat_flag port does not exist.

Decomposition:
- Package mac_seq_pkg:
  - state typedef (IDLE, RUN, DRAIN, DONE), 2-bit encoding.
  - MAC_PRODUCT_SUM_W=17 constant.
  - default MAC_LATENCY, ACC_WIDTH, LEN_WIDTH constants.
- Sub-module mac_valid_pipe: parameterised-depth shift register with async active-low clear, outputs tail bit and an all-zero flag.

Test Plan:
- Directed dot product: cmd_len=3 with beats (a0,b0,a1,b1) = (1,2,3,4), (-5,6,7,-8), (127,127,-128,-128); model mac_result as ideal after MAC_LATENCY. Required: one result 14-86+32513 = 32441; ovalid 5 cycles after the last accept.
- cmd_len=0: ovalid the cycle after accept with result 0, iready never high.
- ivalid gaps: cmd_len=4 with ivalid toggling 1,0,1,0,... Required: exactly 4 beats accepted, sum correct, no extra accumulation from idle cycles.
- Backpressure: hold oready=0 for 10 cycles in DONE. Required: result stable, cmd_ready=0, iready=0; releases to IDLE on accept.
- Reset mid-RUN: resetn low for 1 cycle after 2 of 5 beats. Required: all outputs 0 and state IDLE; the next command (len=1, 2*3+0*0) yields 6.
- MAC_SEQ_SAT_EN with ACC_WIDTH=18: 10 beats of (127,127,127,127). Required: result 131071 and sat_flag=1. Without the macro, result is the wrapped value 322580 mod 2^18 = 60436.
